// File: rtl/seq_divider.sv
// Unsigned restoring divider: one quotient bit per clock, results held until the next completion.
// state  | meaning
// IDLE   | waiting for start; last results held on q/r/dz/ZF
// RUN    | iterating, one quotient bit per edge
// DONE   | one-cycle done strobe, then back to IDLE
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dz,
  output logic             ZF
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dz_q, dz_d;
  logic             zf_q, zf_d;

  // Partial remainder stays below the divisor, so WIDTH+1 bits hold the shifted value and the signed trial.
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             trial_neg;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (b == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  always_comb begin
    shifted   = {rem_q, dvd_q[WIDTH-1]};
    trial     = shifted - {1'b0, dsr_q};
    trial_neg = trial[WIDTH];
    rem_step  = trial_neg ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_step  = {dvd_q[WIDTH-2:0], ~trial_neg};
  end

  always_comb begin
    cnt_d = cnt_q;
    rem_d = rem_q;
    dvd_d = dvd_q;
    dsr_d = dsr_q;
    q_d   = q_q;
    r_d   = r_q;
    dz_d  = dz_q;
    zf_d  = zf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dsr_d = b;
          if (b != '0) begin
            cnt_d = '0;
            rem_d = '0;
            dvd_d = a;
          end else begin
            q_d  = '1;
            r_d  = a;
            dz_d = 1'b1;
            zf_d = 1'b0;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        rem_d = rem_step;
        dvd_d = quo_step;
        // Results are published only on the final step so partial quotients never reach q.
        if (cnt_q == CNT_LAST) begin
          q_d  = quo_step;
          r_d  = rem_step;
          dz_d = 1'b0;
          zf_d = (quo_step == '0);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      rem_q <= '0;
      dvd_q <= '0;
      dsr_q <= '0;
      q_q   <= '0;
      r_q   <= '0;
      dz_q  <= 1'b0;
      zf_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      dvd_q <= dvd_d;
      dsr_q <= dsr_d;
      q_q   <= q_d;
      r_q   <= r_d;
      dz_q  <= dz_d;
      zf_q  <= zf_d;
    end
  end

  assign q  = q_q;
  assign r  = r_q;
  assign dz = dz_q;
  assign ZF = zf_q;

endmodule
